// File: rtl/HighLevelControl.sv
// Shared arbiter types for the unified memory port.
// FSM states and grant identities.
package HighLevelControl;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_FETCH,
    ARB_DATA
  } arbState;

  typedef enum logic {
    GRANT_FETCH,
    GRANT_DATA
  } arbGrant;

endpackage

// File: rtl/mem_wait_counter.sv
// Counts MemReq cycles without MemReady.
// tc flags the last allowed wait cycle.
module mem_wait_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int W =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  assign tc = (cnt == LAST);

  // saturating wait count, cleared while idle
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one memory port between fetch and data access.
// Alternating priority, ready handshake, wait timeout.
module unified_mem_arbiter
  import HighLevelControl::*;
#(
  parameter int WORD_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   FetchReq,
  input  logic [WORD_SIZE-1:0]   FetchAddr,
  output logic [WORD_SIZE-1:0]   FetchInstr,
  output logic                   FetchValid,
  input  logic                   DataEn,
  input  logic                   DataWrite,
  input  logic [WORD_SIZE/8-1:0] DataByteEn,
  input  logic [WORD_SIZE-1:0]   DataAddr,
  input  logic [WORD_SIZE-1:0]   DataWData,
  output logic [WORD_SIZE-1:0]   DataRData,
  output logic                   DataValid,
  output logic                   BusError,
  output logic                   StallF,
  output logic                   StallM,
  output logic                   MemReq,
  output logic                   MemWrite,
  output logic [WORD_SIZE/8-1:0] MemByteEn,
  output logic [WORD_SIZE-1:0]   MemAddr,
  output logic [WORD_SIZE-1:0]   MemWData,
  input  logic [WORD_SIZE-1:0]   MemRData,
  input  logic                   MemReady
);

  arbState state, state_nxt;
  arbGrant last_grant, grant_nxt;

  logic fetch_eff, data_eff;
  logic idle, wait_tc, done, timeout;

  assign fetch_eff = FetchReq & ~FetchValid;
  assign data_eff  = DataEn & ~DataValid;
  assign StallF    = fetch_eff;
  assign StallM    = data_eff;

  assign idle    = (state == ARB_IDLE);
  assign MemReq  = ~idle;
  assign done    = MemReq & (MemReady | wait_tc);
  assign timeout = MemReq & ~MemReady & wait_tc;

  mem_wait_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait (
    .clk   (clk),
    .reset (reset),
    .clear (idle),
    .en    (MemReq & ~MemReady),
    .tc    (wait_tc)
  );

  // state and last-grant registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_grant <= GRANT_DATA;
    end else begin
      state      <= state_nxt;
      last_grant <= grant_nxt;
    end
  end

  // grant selection and access completion
  always_comb begin
    state_nxt = state;
    grant_nxt = last_grant;
    unique case (state)
      ARB_IDLE: begin
        unique case (1'b1)
          fetch_eff & data_eff:
            grant_nxt = (last_grant == GRANT_DATA)
                      ? GRANT_FETCH : GRANT_DATA;
          fetch_eff & ~data_eff:
            grant_nxt = GRANT_FETCH;
          ~fetch_eff & data_eff:
            grant_nxt = GRANT_DATA;
          default: grant_nxt = last_grant;
        endcase
        if (fetch_eff | data_eff) begin
          state_nxt = (grant_nxt == GRANT_FETCH)
                    ? ARB_FETCH : ARB_DATA;
        end
      end
      ARB_FETCH, ARB_DATA: begin
        if (done) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // memory port mux from the granted requester
  always_comb begin
    MemWrite  = 1'b0;
    MemByteEn = '0;
    MemAddr   = '0;
    MemWData  = '0;
    unique case (state)
      ARB_FETCH: begin
        MemByteEn = '1;
        MemAddr   = FetchAddr;
      end
      ARB_DATA: begin
        MemWrite  = DataWrite;
        MemByteEn = DataWrite ? DataByteEn : '1;
        MemAddr   = DataAddr;
        MemWData  = DataWData;
      end
      default: MemWrite = 1'b0;
    endcase
  end

  // completion pulses and captured read data
  always_ff @(posedge clk) begin
    if (reset) begin
      FetchValid <= 1'b0;
      DataValid  <= 1'b0;
      BusError   <= 1'b0;
      FetchInstr <= '0;
      DataRData  <= '0;
    end else begin
      FetchValid <= done & (state == ARB_FETCH);
      DataValid  <= done & (state == ARB_DATA);
      BusError   <= timeout;
      if (done && state == ARB_FETCH) begin
        FetchInstr <= MemReady ? MemRData : '0;
      end
      if (done && state == ARB_DATA && !DataWrite) begin
        DataRData <= MemReady ? MemRData : '0;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: vector table,
// reference arbiter model and per-port scoreboards.
module tb_unified_mem_arbiter;

  localparam int W  = 32;
  localparam int TO = 16;
  localparam bit GF = 1'b0;
  localparam bit GD = 1'b1;

  logic          clk = 1'b0;
  logic          reset;
  logic          FetchReq;
  logic [W-1:0]  FetchAddr;
  logic [W-1:0]  FetchInstr;
  logic          FetchValid;
  logic          DataEn;
  logic          DataWrite;
  logic [3:0]    DataByteEn;
  logic [W-1:0]  DataAddr;
  logic [W-1:0]  DataWData;
  logic [W-1:0]  DataRData;
  logic          DataValid;
  logic          BusError;
  logic          StallF;
  logic          StallM;
  logic          MemReq;
  logic          MemWrite;
  logic [3:0]    MemByteEn;
  logic [W-1:0]  MemAddr;
  logic [W-1:0]  MemWData;
  logic [W-1:0]  MemRData;
  logic          MemReady;

  unified_mem_arbiter #(
    .WORD_SIZE(W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .FetchReq(FetchReq), .FetchAddr(FetchAddr),
    .FetchInstr(FetchInstr), .FetchValid(FetchValid),
    .DataEn(DataEn), .DataWrite(DataWrite),
    .DataByteEn(DataByteEn), .DataAddr(DataAddr),
    .DataWData(DataWData), .DataRData(DataRData),
    .DataValid(DataValid), .BusError(BusError),
    .StallF(StallF), .StallM(StallM),
    .MemReq(MemReq), .MemWrite(MemWrite),
    .MemByteEn(MemByteEn), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemRData(MemRData),
    .MemReady(MemReady)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          nf;
    int          nd;
    logic [31:0] fa;
    logic [31:0] da;
    logic        dw;
    logic [3:0]  be;
    logic [31:0] wd;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        st;
    int          len;
  } exp_t;

  exp_t        fq[$];
  exp_t        dq[$];
  logic [31:0] img [int];
  vec_t        vecs [10];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit          exp_req, done_prev, err_prev;
  bit          cg, pg, lastg;
  int          cur_len, last_len, lat;
  int          fi, di;
  bit          fpend, dpend;
  logic [31:0] cur_fa, cur_da, cur_wd, last_ld;
  logic        cur_dw;
  logic [3:0]  cur_be;
  string       vname;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %h want %h",
               vname, nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s/%s", vname, nm);
  endtask

  function automatic logic [31:0] img_read(
    input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (img.exists(int'(wa >> 2))) return img[int'(wa >> 2)];
    return {wa[15:0] ^ 16'hC3A5, ~wa[15:0]};
  endfunction

  task automatic model_reset();
    exp_req   = 0;
    done_prev = 0;
    err_prev  = 0;
    lastg     = GD;
    cg        = GD;
    pg        = GD;
    cur_len   = 0;
    last_ld   = '0;
  endtask

  task automatic check_zero(input string tag);
    vname = tag;
    chk("FetchInstr", FetchInstr, 0);
    chk("DataRData", DataRData, 0);
    chk("FetchValid", FetchValid, 0);
    chk("DataValid", DataValid, 0);
    chk("BusError", BusError, 0);
    chk("MemReq", MemReq, 0);
    chk("MemWrite", MemWrite, 0);
    chk("MemByteEn", MemByteEn, 0);
    chk("MemAddr", MemAddr, 0);
    chk("MemWData", MemWData, 0);
    chk("StallF", StallF, 0);
    chk("StallM", StallM, 0);
  endtask

  // drive requests and memory response after the edge
  task automatic drive(input vec_t v);
    exp_t e;
    bit   to;
    @(posedge clk);
    #1;
    to = (v.lat >= TO);
    if (!fpend) begin
      if (fi < v.nf) begin
        cur_fa    = v.fa + 32'(4 * fi);
        FetchReq  = 1'b1;
        FetchAddr = cur_fa;
        e.data    = to ? 32'h0 : img_read(cur_fa);
        e.err     = to;
        e.st      = 1'b0;
        e.len     = to ? TO : v.lat + 1;
        fq.push_back(e);
        fi++;
        fpend = 1;
      end else begin
        FetchReq = 1'b0;
      end
    end
    if (!dpend) begin
      if (di < v.nd) begin
        cur_da     = v.da + 32'(4 * di);
        cur_dw     = v.dw;
        cur_be     = v.be;
        cur_wd     = v.wd + 32'(di);
        DataEn     = 1'b1;
        DataAddr   = cur_da;
        DataWrite  = cur_dw;
        DataByteEn = cur_be;
        DataWData  = cur_wd;
        e.data     = (to || v.dw) ? 32'h0 : img_read(cur_da);
        e.err      = to;
        e.st       = v.dw;
        e.len      = to ? TO : v.lat + 1;
        dq.push_back(e);
        di++;
        dpend = 1;
      end else begin
        DataEn = 1'b0;
      end
    end
    MemReady = MemReq && (cur_len == lat);
    MemRData = MemReady ? img_read(MemAddr) : 32'hDEAD_BEEF;
  endtask

  // compare DUT against the model mid-cycle
  task automatic observe();
    bit          ef, ed, eff_f, eff_d;
    bit          done_now, err_now, nreq;
    exp_t        e;
    logic [31:0] w;
    @(negedge clk);
    ef = done_prev && (pg == GF);
    ed = done_prev && (pg == GD);
    chk("FetchValid", FetchValid, ef);
    chk("DataValid", DataValid, ed);
    chk("BusError", BusError, done_prev && err_prev);
    chk("MemReq", MemReq, exp_req);
    chk("StallF", StallF, FetchReq && !ef);
    chk("StallM", StallM, DataEn && !ed);
    if (ef) begin
      if (fq.size() == 0) fail("fetch_q_empty");
      else begin
        e = fq.pop_front();
        chk("FetchInstr", FetchInstr, e.data);
        chk("f_len", last_len, e.len);
      end
      fpend = 0;
    end
    if (ed) begin
      if (dq.size() == 0) fail("data_q_empty");
      else begin
        e = dq.pop_front();
        if (e.st) begin
          chk("st_keep_rdata", DataRData, last_ld);
        end else begin
          chk("DataRData", DataRData, e.data);
          last_ld = e.data;
        end
        chk("d_len", last_len, e.len);
      end
      dpend = 0;
    end
    done_now = 0;
    err_now  = 0;
    if (exp_req) begin
      cur_len++;
      if (cur_len == 1) begin
        if (cg == GF) begin
          chk("f_addr", MemAddr, cur_fa);
          chk("f_we", MemWrite, 0);
          chk("f_be", MemByteEn, 4'hF);
        end else begin
          chk("d_addr", MemAddr, cur_da);
          chk("d_we", MemWrite, cur_dw);
          chk("d_be", MemByteEn, cur_dw ? cur_be : 4'hF);
          if (cur_dw) chk("d_wdata", MemWData, cur_wd);
        end
      end
      if (MemReady && cg == GD && cur_dw) begin
        w = img_read(cur_da);
        for (int b = 0; b < 4; b++)
          if (cur_be[b]) w[8*b +: 8] = cur_wd[8*b +: 8];
        img[int'(cur_da >> 2)] = w;
      end
      done_now = MemReady || (cur_len == TO);
      err_now  = !MemReady && (cur_len == TO);
      if (done_now) last_len = cur_len;
      pg   = cg;
      nreq = !done_now;
    end else begin
      cur_len = 0;
      eff_f   = FetchReq && !ef;
      eff_d   = DataEn && !ed;
      nreq    = eff_f || eff_d;
      if (eff_f && eff_d) cg = ~lastg;
      else if (eff_f)     cg = GF;
      else if (eff_d)     cg = GD;
      if (nreq) lastg = cg;
    end
    done_prev = done_now;
    err_prev  = err_now;
    exp_req   = nreq;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    cyc   = 0;
    vname = v.name;
    fi    = 0;
    di    = 0;
    fpend = 0;
    dpend = 0;
    lat   = v.lat;
    while ((fi < v.nf || di < v.nd || fpend || dpend)
           && cyc < 200) begin
      drive(v);
      observe();
      cyc++;
    end
    if (cyc >= 200) fail("cycle_budget_expired");
    repeat (2) begin
      drive(v);
      observe();
    end
  endtask

  initial begin
    reset      = 1'b1;
    FetchReq   = 1'b0;
    FetchAddr  = '0;
    DataEn     = 1'b0;
    DataWrite  = 1'b0;
    DataByteEn = '0;
    DataAddr   = '0;
    DataWData  = '0;
    MemRData   = '0;
    MemReady   = 1'b0;
    model_reset();
    img[32'h100 >> 2] = 32'h0050_0093;

    vecs[0] = '{"both_after_reset", 2, 1, 32'h100, 32'h200,
                1'b0, 4'h0, 32'h0, 1};
    vecs[1] = '{"fetch_only", 1, 0, 32'h100, 32'h0,
                1'b0, 4'h0, 32'h0, 1};
    vecs[2] = '{"sb_0x203", 0, 1, 32'h0, 32'h203,
                1'b1, 4'b0001, 32'hAB, 0};
    vecs[3] = '{"lw_after_sb", 0, 1, 32'h0, 32'h200,
                1'b0, 4'h0, 32'h0, 2};
    vecs[4] = '{"timeout_load", 0, 1, 32'h0, 32'h240,
                1'b0, 4'h0, 32'h0, 99};
    vecs[5] = '{"ready_16th", 0, 1, 32'h0, 32'h244,
                1'b0, 4'h0, 32'h0, 15};
    vecs[6] = '{"timeout_fetch", 1, 0, 32'h180, 32'h0,
                1'b0, 4'h0, 32'h0, 99};
    vecs[7] = '{"alternate20", 10, 10, 32'h400, 32'h800,
                1'b0, 4'h0, 32'h0, 0};
    vecs[8] = '{"sh_lat3", 0, 1, 32'h0, 32'h250,
                1'b1, 4'b1100, 32'h1234_5678, 3};
    vecs[9] = '{"mixed_readback", 1, 1, 32'h104, 32'h250,
                1'b0, 4'h0, 32'h0, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");

    // stalled fetch cut short by reset
    vname = "reset_mid_access";
    @(posedge clk); #1;
    reset     = 1'b0;
    FetchReq  = 1'b1;
    FetchAddr = 32'h300;
    @(negedge clk);
    chk("idle_req", MemReq, 0);
    chk("stallf_req", StallF, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("req_cyc1", MemReq, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("req_cyc2", MemReq, 1);
    @(posedge clk); #1;
    reset    = 1'b1;
    FetchReq = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_zero("after_mid_reset");
    vname = "reset_mid_access";
    repeat (3) begin
      @(negedge clk);
      chk("no_valid", FetchValid, 0);
      chk("no_req", MemReq, 0);
    end
    model_reset();

    foreach (vecs[i]) run_vec(vecs[i]);

    vname = "end";
    if (fq.size() != 0) fail("fetch_q_left");
    if (dq.size() != 0) fail("data_q_left");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
